reg_to_tlul_fsm: RTL

REG_TO_TLUL_FSM -- requirements
Module: reg_to_tlul_fsm

---
 rtl/reg_to_tlul_fsm_pkg.sv | 22 ++
 rtl/tlul_pkg.sv | 50 +++++
 rtl/reg_to_tlul_fsm.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/reg_to_tlul_fsm_pkg.sv
// Register-interface request/response payloads used by the reg-to-TL-UL bridge.
package reg_to_tlul_fsm_pkg;

    localparam int unsigned REG_AW = 32;
    localparam int unsigned REG_DW = 32;
    localparam int unsigned REG_SW = REG_DW / 8;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] wdata;
        logic [REG_SW-1:0] wstrb;
    } reg_req_t;

    typedef struct packed {
        logic              ready;
        logic [REG_DW-1:0] rdata;
        logic              error;
    } reg_rsp_t;

endpackage

// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: field widths, opcode encodings and channel payloads.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_DBW = TL_DW / 8;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DIW = 1;
    localparam int unsigned TL_SZW = 2;
    localparam int unsigned TL_AUW = 16;
    localparam int unsigned TL_DUW = 16;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic [TL_AUW-1:0]   a_user;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic [TL_DUW-1:0]   d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/reg_to_tlul_fsm.sv
// Bridges one register-interface access at a time onto a TL-UL host port,
// with an optional response timeout that drains the late beat afterwards.
module reg_to_tlul_fsm
    import reg_to_tlul_fsm_pkg::*;
#(
    parameter type         req_t             = reg_req_t,
    parameter type         rsp_t             = reg_rsp_t,
    parameter type         tl_h2d_t          = tlul_pkg::tl_h2d_t,
    parameter type         tl_d2h_t          = tlul_pkg::tl_d2h_t,
    parameter type         tl_a_user_t       = logic [tlul_pkg::TL_AUW-1:0],
    parameter tl_a_user_t  TL_A_USER_DEFAULT = '0,
    parameter int unsigned DW                = 32,
    parameter int unsigned SourceId          = 0,
    parameter int unsigned TimeoutCycles     = 0
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  req_t    reg_req_i,
    output rsp_t    reg_rsp_o,
    output tl_h2d_t tl_o,
    input  tl_d2h_t tl_i
);

    localparam int unsigned MaskW   = DW / 8;
    localparam int unsigned SizeVal = $clog2(MaskW);
    localparam int unsigned SzW     = tlul_pkg::TL_SZW;
    localparam int unsigned IdW     = tlul_pkg::TL_AIW;
    localparam int unsigned CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
    localparam logic [IdW-1:0]  SrcId  = IdW'(SourceId);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        DONE,
        DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic                error_q, error_d;
    logic                drain_q, drain_d;
    logic                a_valid_q, d_ready_q, ready_q;

    logic                write_q;
    logic [REG_AW-1:0]   addr_q;
    logic [DW-1:0]       wdata_q;
    logic [MaskW-1:0]    mask_q;
    tlul_pkg::tl_a_op_e  opcode_q;

    logic                capture;
    logic                unused_d;

    assign capture  = (state_q == IDLE) && reg_req_i.valid;
    assign unused_d = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

    // Request capture; opcode and mask are resolved here so the A channel is flop-driven.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            opcode_q <= tlul_pkg::PutFullData;
        end else if (capture) begin
            write_q  <= reg_req_i.write;
            addr_q   <= reg_req_i.addr;
            wdata_q  <= reg_req_i.wdata;
            mask_q   <= reg_req_i.write ? reg_req_i.wstrb : '1;
            if (!reg_req_i.write) begin
                opcode_q <= tlul_pkg::Get;
            end else if (&reg_req_i.wstrb) begin
                opcode_q <= tlul_pkg::PutFullData;
            end else begin
                opcode_q <= tlul_pkg::PutPartialData;
            end
        end
    end

    // State, response and handshake registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            drain_q   <= 1'b0;
            a_valid_q <= 1'b0;
            d_ready_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            drain_q   <= drain_d;
            a_valid_q <= (state_d == ADDR);
            d_ready_q <= (state_d == DATA) || (state_d == DRAIN);
            ready_q   <= (state_d == DONE);
        end
    end

    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

    // Next-state logic; a response beat wins over a timeout expiring in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        error_d = error_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (reg_req_i.valid) begin
                    if (reg_req_i.write && (reg_req_i.wstrb == '0)) begin
                        state_d = DONE;
                        rdata_d = '0;
                        error_d = 1'b0;
                        drain_d = 1'b0;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (tl_i.a_ready) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (tl_i.d_valid) begin
                    state_d = DONE;
                    drain_d = 1'b0;
                    if (tl_i.d_source == SrcId) begin
                        rdata_d = write_q ? '0 : tl_i.d_data;
                        error_d = tl_i.d_error;
                    end else begin
                        rdata_d = '0;
                        error_d = 1'b1;
                    end
                end else if (TimeoutCycles != 0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntMax) begin
                        state_d = DONE;
                        rdata_d = '0;
                        error_d = 1'b1;
                        drain_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = drain_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (tl_i.d_valid) begin
                    state_d = IDLE;
                    drain_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid_q;
        tl_o.a_opcode  = opcode_q;
        tl_o.a_param   = '0;
        tl_o.a_size    = SzW'(SizeVal);
        tl_o.a_source  = SrcId;
        tl_o.a_address = addr_q;
        tl_o.a_mask    = mask_q;
        tl_o.a_data    = wdata_q;
        tl_o.a_user    = TL_A_USER_DEFAULT;
        tl_o.d_ready   = d_ready_q;
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = ready_q;
        reg_rsp_o.rdata = rdata_q;
        reg_rsp_o.error = error_q;
    end

endmodule
